// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//
// Instruction-register and decode stage of the multicycle MIPS CPU.
//
// Behaviour:
//   - The IR is loaded from unified memory on an irWe edge.
//   - The same edge registers the 4-bit command code for the control FSM.
//   - The MDR samples memData on every edge.
//   - Register indices and extended immediates are sliced combinationally
//     from the IR.
//   - Illegal instructions are tracked with a sticky flag and a saturating
//     counter.
//
// Load strobe semantics:
//   irWe is a single-cycle load strobe with no back-pressure. When irWe=1 on
//   a rising edge, memData is captured and ir/cmd reflect it from the
//   following cycle. While irWe=0, ir and cmd hold.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (priority over everything)
//   irWe     in   load IR and cmd from memData this edge
//   clrErr   in   clear errFlag/errCnt (priority over an illegal load)
//   memData  in   [WIDTH-1:0] memory read data
//   cmd      out  [3:0] registered command code
//   rs/rt/rd out  [4:0] register indices IR[25:21]/IR[20:16]/IR[15:11]
//   sxi      out  [WIDTH-1:0] sign-extended IR[15:0]
//   sxis     out  [WIDTH-1:0] sxi << 2
//   jaddr    out  [25:0] IR[25:0]
//   mdr      out  [WIDTH-1:0] memory data register
//   illegal  out  cmd is the illegal code
//   errFlag  out  sticky illegal-load flag
//   errCnt   out  [CNT_W-1:0] saturating illegal-load count
// -----------------------------------------------------------------------------
module instr_decode #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irWe,
  input  logic             clrErr,
  input  logic [WIDTH-1:0] memData,
  output logic [3:0]       cmd,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] sxi,
  output logic [WIDTH-1:0] sxis,
  output logic [25:0]      jaddr,
  output logic [WIDTH-1:0] mdr,
  output logic             illegal,
  output logic             errFlag,
  output logic [CNT_W-1:0] errCnt
);

  localparam logic [3:0] CMD_LW   = 4'd0;
  localparam logic [3:0] CMD_SW   = 4'd1;
  localparam logic [3:0] CMD_J    = 4'd2;
  localparam logic [3:0] CMD_JR   = 4'd3;
  localparam logic [3:0] CMD_JAL  = 4'd4;
  localparam logic [3:0] CMD_BEQ  = 4'd5;
  localparam logic [3:0] CMD_BNE  = 4'd6;
  localparam logic [3:0] CMD_XORI = 4'd7;
  localparam logic [3:0] CMD_ADDI = 4'd8;
  localparam logic [3:0] CMD_ADD  = 4'd9;
  localparam logic [3:0] CMD_SUB  = 4'd10;
  localparam logic [3:0] CMD_SLT  = 4'd11;
  localparam logic [3:0] CMD_ILL  = 4'd15;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Only IR[25:0] is kept.
  // The opcode bits are consumed by decode at load time and feed no
  // field output.
  logic [25:0]      ir_q,       ir_d;
  logic [3:0]       cmd_q,      cmd_d;
  logic [WIDTH-1:0] mdr_q,      mdr_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
  logic [3:0]       dec_cmd;

  function automatic logic [3:0] decode(input logic [WIDTH-1:0] w);
    logic [3:0] c;
    c = CMD_ILL;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h08: c = CMD_JR;
          6'h20: c = CMD_ADD;
          6'h22: c = CMD_SUB;
          6'h2A: c = CMD_SLT;
          // The all-zero NOP is executed as ADD $0,$0,$0.
          // Any other funct-0 word is illegal.
          6'h00: c = (w == '0) ? CMD_ADD : CMD_ILL;
          default: c = CMD_ILL;
        endcase
      end
      6'h02:   c = CMD_J;
      6'h03:   c = CMD_JAL;
      6'h04:   c = CMD_BEQ;
      6'h05:   c = CMD_BNE;
      6'h08:   c = CMD_ADDI;
      6'h0E:   c = CMD_XORI;
      6'h23:   c = CMD_LW;
      6'h2B:   c = CMD_SW;
      default: c = CMD_ILL;
    endcase
    return c;
  endfunction

  always_comb begin
    dec_cmd    = decode(memData);
    ir_d       = ir_q;
    cmd_d      = cmd_q;
    mdr_d      = memData;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;

    if (irWe) begin
      ir_d  = memData[25:0];
      cmd_d = dec_cmd;
    end

    // A clear wins over a simultaneous illegal load.
    // The IR/cmd load above still happens.
    if (clrErr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = '0;
    end else if (irWe && (dec_cmd == CMD_ILL)) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q       <= '0;
      cmd_q      <= CMD_ADD;  // decode of the all-zero reset IR
      mdr_q      <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      ir_q       <= ir_d;
      cmd_q      <= cmd_d;
      mdr_q      <= mdr_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign cmd     = cmd_q;
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign sxi     = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign sxis    = {sxi[WIDTH-3:0], 2'b00};
  assign jaddr   = ir_q[25:0];
  assign mdr     = mdr_q;
  assign illegal = (cmd_q == CMD_ILL);
  assign errFlag = err_flag_q;
  assign errCnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_decode
//
// Bench structure:
//   - Two instances share all inputs: the default CNT_W=8 build and a
//     CNT_W=2 build that exercises counter saturation.
//   - Each step drives inputs and updates a small reference model.
//   - The expected post-edge state is pushed to exp_q, then popped and
//     compared one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_decode;

  localparam int W  = 32;
  localparam int EW = 26 + W + 4 + 1 + 8 + 2;  // ir, mdr, cmd, flag, cnt8, cnt2

  logic         clk = 1'b0;
  logic         reset;
  logic         irWe;
  logic         clrErr;
  logic [W-1:0] memData;

  logic [3:0]   cmd,  cmd2;
  logic [4:0]   rs,   rs2;
  logic [4:0]   rt,   rt2;
  logic [4:0]   rd,   rd2;
  logic [W-1:0] sxi,  sxi2;
  logic [W-1:0] sxis, sxis2;
  logic [25:0]  jaddr, jaddr2;
  logic [W-1:0] mdr,  mdr2;
  logic         illegal, illegal2;
  logic         errFlag, errFlag2;
  logic [7:0]   errCnt;
  logic [1:0]   errCnt2;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state.
  logic [25:0]  m_ir;
  logic [W-1:0] m_mdr;
  logic [3:0]   m_cmd;
  logic         m_flag;
  logic [7:0]   m_cnt;
  logic [1:0]   m_cnt2;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Devices under test
  // ---------------------------------------------------------------------------
  instr_decode #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .irWe(irWe), .clrErr(clrErr), .memData(memData),
    .cmd(cmd), .rs(rs), .rt(rt), .rd(rd), .sxi(sxi), .sxis(sxis),
    .jaddr(jaddr), .mdr(mdr), .illegal(illegal), .errFlag(errFlag),
    .errCnt(errCnt)
  );

  instr_decode #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .irWe(irWe), .clrErr(clrErr), .memData(memData),
    .cmd(cmd2), .rs(rs2), .rt(rt2), .rd(rd2), .sxi(sxi2), .sxis(sxis2),
    .jaddr(jaddr2), .mdr(mdr2), .illegal(illegal2), .errFlag(errFlag2),
    .errCnt(errCnt2)
  );

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock step.
  //   dcmd is the expected decode of w (used only when we=1).
  // ---------------------------------------------------------------------------
  task automatic step(input logic [W-1:0] w, input logic we, input logic clr,
                      input logic rst, input logic [3:0] dcmd);
    logic [EW-1:0] e;
    logic [25:0]   e_ir;
    logic [W-1:0]  e_mdr;
    logic [3:0]    e_cmd;
    logic          e_flag;
    logic [7:0]    e_cnt;
    logic [1:0]    e_cnt2;
    logic [W-1:0]  e_sxi;

    memData = w;
    irWe    = we;
    clrErr  = clr;
    reset   = rst;

    if (rst) begin
      m_ir = '0; m_mdr = '0; m_cmd = 4'd9; m_flag = 1'b0; m_cnt = '0; m_cnt2 = '0;
    end else begin
      m_mdr = w;
      if (we) begin
        m_ir  = w[25:0];
        m_cmd = dcmd;
      end
      if (clr) begin
        m_flag = 1'b0; m_cnt = '0; m_cnt2 = '0;
      end else if (we && dcmd == 4'd15) begin
        m_flag = 1'b1;
        if (m_cnt  != 8'hFF) m_cnt  = m_cnt + 8'd1;
        if (m_cnt2 != 2'd3)  m_cnt2 = m_cnt2 + 2'd1;
      end
    end
    exp_q.push_back({m_ir, m_mdr, m_cmd, m_flag, m_cnt, m_cnt2});

    @(posedge clk);
    #1;

    e = exp_q.pop_front();
    {e_ir, e_mdr, e_cmd, e_flag, e_cnt, e_cnt2} = e;
    e_sxi = {{16{e_ir[15]}}, e_ir[15:0]};

    chk("cmd",      {28'd0, cmd},      {28'd0, e_cmd});
    chk("illegal",  {31'd0, illegal},  {31'd0, (e_cmd == 4'd15)});
    chk("rs",       {27'd0, rs},       {27'd0, e_ir[25:21]});
    chk("rt",       {27'd0, rt},       {27'd0, e_ir[20:16]});
    chk("rd",       {27'd0, rd},       {27'd0, e_ir[15:11]});
    chk("sxi",      sxi,               e_sxi);
    chk("sxis",     sxis,              {e_sxi[29:0], 2'b00});
    chk("jaddr",    {6'd0, jaddr},     {6'd0, e_ir});
    chk("mdr",      mdr,               e_mdr);
    chk("errFlag",  {31'd0, errFlag},  {31'd0, e_flag});
    chk("errCnt",   {24'd0, errCnt},   {24'd0, e_cnt});
    chk("cmd2",     {28'd0, cmd2},     {28'd0, e_cmd});
    chk("errFlag2", {31'd0, errFlag2}, {31'd0, e_flag});
    chk("errCnt2",  {30'd0, errCnt2},  {30'd0, e_cnt2});
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] rw;

    reset = 1'b1; irWe = 1'b0; clrErr = 1'b0; memData = '0;
    m_ir = '0; m_mdr = '0; m_cmd = 4'd9; m_flag = 1'b0; m_cnt = '0; m_cnt2 = '0;

    // Reset, then idle.
    step(32'h0, 1'b0, 1'b0, 1'b1, 4'd9);
    step(32'h0, 1'b0, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) step(32'h0, 1'b0, 1'b0, 1'b0, 4'd9);

    // ADD r3,r1,r2; then hold while mdr tracks memData.
    step(32'h00221820, 1'b1, 1'b0, 1'b0, 4'd9);
    step(32'h12345678, 1'b0, 1'b0, 1'b0, 4'd0);
    step(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 4'd0);

    // LW, BEQ with negative offset, J.
    step(32'h8C850008, 1'b1, 1'b0, 1'b0, 4'd0);
    step(32'h1022FFFF, 1'b1, 1'b0, 1'b0, 4'd5);
    step(32'h08000004, 1'b1, 1'b0, 1'b0, 4'd2);

    // R-type funct sweep and illegal funct-0 words.
    step(32'h00221808, 1'b1, 1'b0, 1'b0, 4'd3);
    step(32'h00221820, 1'b1, 1'b0, 1'b0, 4'd9);
    step(32'h00221822, 1'b1, 1'b0, 1'b0, 4'd10);
    step(32'h0022182A, 1'b1, 1'b0, 1'b0, 4'd11);
    step(32'h00221800, 1'b1, 1'b0, 1'b0, 4'd15);
    step(32'h00200000, 1'b1, 1'b0, 1'b0, 4'd15);
    step(32'h00000000, 1'b1, 1'b0, 1'b0, 4'd9);   // NOP is ADD

    // I-type sweep.
    step(32'h3843ABCD, 1'b1, 1'b0, 1'b0, 4'd7);
    step(32'h20A58001, 1'b1, 1'b0, 1'b0, 4'd8);
    step(32'hAC000010, 1'b1, 1'b0, 1'b0, 4'd1);
    step(32'h14000003, 1'b1, 1'b0, 1'b0, 4'd6);
    step(32'h0C3FFFFF, 1'b1, 1'b0, 1'b0, 4'd4);

    // Clear with irWe=0, then three illegal loads.
    step(32'h00000000, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(32'hFC000000, 1'b1, 1'b0, 1'b0, 4'd15);

    // Fourth illegal load with clrErr: the clear wins.
    step(32'hFC000000, 1'b1, 1'b1, 1'b0, 4'd15);

    // Five illegal loads: the CNT_W=2 instance saturates at 3.
    for (int i = 0; i < 5; i++) step(32'hFC000000, 1'b1, 1'b0, 1'b0, 4'd15);

    // Reset mid-stream with irWe asserted.
    step(32'hFC000000, 1'b1, 1'b0, 1'b1, 4'd15);

    // Random ADD and LW words.
    for (int i = 0; i < 6; i++) begin
      rw = {6'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'd0, 6'h20};
      step(rw, 1'b1, 1'b0, 1'b0, 4'd9);
      rw = {6'h23, 26'($urandom_range(0, 32'h03FFFFFF))};
      step(rw, 1'b1, 1'b0, 1'b0, 4'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
